// File: rtl/cache_pkg.sv
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared types, address-split constants and byte-lane helper for
//            the direct-mapped write-through data cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_BITS = 2;
    localparam int BYTE_LANES  = 4;
    localparam int INDEX_DFLT  = 4;
    localparam int TAG_BITS    = ADDR_BITS - INDEX_DFLT - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } cache_state_t;

    // Byte load result: selected lane, zero-extended.
    function automatic logic [31:0] lane_sel(input logic [31:0] word,
                                             input logic [1:0]  offset);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        return {24'h0, shifted[7:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_cache_array.sv
// ============================================================================
// Module   : data_cache_array
// Brief    : Valid/tag/data storage; asynchronous read, byte-enable write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_cache_array #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic                  i_fill,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_valid,
    output logic [TAG_W-1:0]      o_tag,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int c_depth = 1 << INDEX_BITS;

    logic [c_depth-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [c_depth];

    // Flush wins over a same-edge fill so a flushed fill is left invalid.
    always_ff @(posedge clk) begin
        if (!i_rst_n || i_flush) begin
            r_valid <= '0;
        end else if (i_fill) begin
            r_valid[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_tag[i_index] <= i_wr_tag;
        end
    end

    for (genvar l = 0; l < DATA_WIDTH/8; l++) begin : g_lane
        logic [7:0] r_lane [c_depth];

        always_ff @(posedge clk) begin
            if (i_wr_be[l]) begin
                r_lane[i_index] <= i_wr_data[8*l +: 8];
            end
        end

        assign o_data[8*l +: 8] = r_lane[i_index];
    end

    assign o_valid = r_valid[i_index];
    assign o_tag   = r_tag[i_index];

endmodule

`default_nettype wire

// File: rtl/data_cache.sv
// ============================================================================
// Module   : data_cache
// Brief    : Direct-mapped, write-through, no-write-allocate data cache with
//            a req/ack memory port and pipeline stall output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic                  re_i,
    input  logic                  we_i,
    input  logic                  byte_op_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    output logic [BYTE_LANES-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int c_tag_w = ADDR_BITS - INDEX_BITS - OFFSET_BITS;

    cache_state_t r_state;
    cache_state_t w_next;

    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_byte_op;
    logic                  r_flush_pend;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_BITS-1:0]  r_mem_addr;
    logic [BYTE_LANES-1:0] r_mem_be;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic [ADDR_BITS-1:0]  w_look_addr;
    logic [INDEX_BITS-1:0] w_index;
    logic [c_tag_w-1:0]    w_tag;
    logic                  w_valid;
    logic [c_tag_w-1:0]    w_line_tag;
    logic [DATA_WIDTH-1:0] w_line_data;
    logic                  w_hit;
    logic                  w_ack;
    logic                  w_fill;
    logic                  w_flush;
    logic [BYTE_LANES-1:0] w_wr_be;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_rd_src;
    logic [1:0]            w_rd_off;
    logic                  w_rd_byte;
    logic                  w_stall;

    // Outside IDLE the lookup follows the captured request.
    assign w_look_addr = (r_state == IDLE) ? addr_i : r_addr;
    assign w_index     = w_look_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_tag       = w_look_addr[ADDR_BITS-1:INDEX_BITS+OFFSET_BITS];
    assign w_hit       = w_valid && (w_line_tag == w_tag);

    assign w_ack   = mem_ack_i && (r_state != IDLE);
    assign w_fill  = mem_ack_i && (r_state == RD_MISS);
    assign w_wr_be = w_fill ? {BYTE_LANES{1'b1}}
                   : ((mem_ack_i && (r_state == WR_THRU) && w_hit) ? r_mem_be : '0);
    assign w_wr_data = w_fill ? mem_rdata_i : r_mem_wdata;
    assign w_flush   = (r_state == IDLE) ? flush_i : (w_ack && (flush_i || r_flush_pend));

    data_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (c_tag_w),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk       (clk),
        .i_rst_n   (rst_n_i),
        .i_flush   (w_flush),
        .i_index   (w_index),
        .i_fill    (w_fill),
        .i_wr_tag  (w_tag),
        .i_wr_be   (w_wr_be),
        .i_wr_data (w_wr_data),
        .o_valid   (w_valid),
        .o_tag     (w_line_tag),
        .o_data    (w_line_data)
    );

    // Load data: bypass from memory on the fill cycle, else from the array.
    assign w_rd_src  = (r_state == RD_MISS) ? mem_rdata_i : w_line_data;
    assign w_rd_off  = (r_state == RD_MISS) ? r_addr[1:0] : addr_i[1:0];
    assign w_rd_byte = (r_state == RD_MISS) ? r_byte_op : byte_op_i;
    assign rd_o      = w_rd_byte ? lane_sel(w_rd_src, w_rd_off) : w_rd_src;

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (we_i) begin
                    w_stall = 1'b1;
                    w_next  = WR_THRU;
                end else if (re_i && !w_hit) begin
                    w_stall = 1'b1;
                    w_next  = RD_MISS;
                end
            end
            RD_MISS, WR_THRU: begin
                w_stall = !mem_ack_i;
                if (mem_ack_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign stall_o = w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_byte_op    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                if (we_i || (re_i && !w_hit)) begin
                    r_addr     <= addr_i;
                    r_byte_op  <= byte_op_i;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= we_i;
                    r_mem_addr <= {addr_i[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                end
                if (we_i) begin
                    r_mem_be    <= byte_op_i ? (4'b0001 << addr_i[1:0]) : 4'hF;
                    r_mem_wdata <= byte_op_i ? {4{wd_i[7:0]}} : wd_i;
                end else if (re_i && !w_hit) begin
                    r_mem_be <= 4'hF;
                end
            end else if (mem_ack_i) begin
                r_mem_req    <= 1'b0;
                r_flush_pend <= 1'b0;
            end else if (flush_i) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_be_o    = r_mem_be;
    assign mem_wdata_o = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
// ============================================================================
// Module   : tb_data_cache
// Brief    : Directed self-checking bench for data_cache with a word-level
//            cache/memory model and per-cycle output comparison.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        re_i, we_i, byte_op_i, flush_i;
    logic [31:0] addr_i, wd_i;
    logic [31:0] rd_o;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    data_cache #(.DATA_WIDTH(32), .INDEX_BITS(4)) dut (
        .clk         (clk),
        .rst_n_i     (rst_n_i),
        .re_i        (re_i),
        .we_i        (we_i),
        .byte_op_i   (byte_op_i),
        .addr_i      (addr_i),
        .wd_i        (wd_i),
        .flush_i     (flush_i),
        .rd_o        (rd_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: backing memory plus set of cached word addresses.
    bit [31:0] mem_arr [bit [31:0]];
    bit [31:0] cached  [bit [31:0]];

    function automatic bit [31:0] mem_read(input bit [31:0] w);
        return mem_arr.exists(w) ? mem_arr[w] : (w ^ 32'h5A5A_0000);
    endfunction

    function automatic int line_of(input bit [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic bit [31:0] pick(input bit [31:0] w, input bit [1:0] off, input bit bop);
        return bop ? ((w >> (8 * off)) & 32'hFF) : w;
    endfunction

    // Current access descriptor shared with the compare process.
    bit        d_active = 0, d_fast = 0, d_we = 0, mon_en = 0;
    int        d_lat = 0, acc_cyc = 0;
    bit [31:0] d_addr, d_rd, d_wdata;
    bit [3:0]  d_be;
    bit [31:0] last_rd, last_wdata;
    bit [3:0]  last_be;
    int        last_stalls;
    bit        last_req_seen;

    // Memory responder: acks after the request has been held resp_lat cycles.
    bit manual_ack = 0;
    int resp_lat = 1;
    int req_cnt = 0;
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!manual_ack) begin
                if (mem_req_o === 1'b1) req_cnt++;
                else req_cnt = 0;
                if (mem_req_o === 1'b1 && req_cnt == resp_lat + 1) begin
                    bit [31:0] v;
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_read(mem_addr_o);
                    if (mem_we_o === 1'b1) begin
                        v = mem_read(mem_addr_o);
                        for (int l = 0; l < 4; l++)
                            if (mem_be_o[l]) v[8*l +: 8] = mem_wdata_o[8*l +: 8];
                        mem_arr[mem_addr_o] = v;
                    end
                    req_cnt = 0;
                end else begin
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = 32'h0;
                end
            end
        end
    end

    // Compare process: checks every cycle of an access and idle cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (d_active) begin
                if (acc_cyc == 0) begin
                    last_stalls   = 0;
                    last_req_seen = 0;
                end
                if (stall_o === 1'b1) last_stalls++;
                if (mem_req_o === 1'b1) last_req_seen = 1;
                if (d_fast) begin
                    check("hit_stall", stall_o, 0);
                    check("hit_req", mem_req_o, 0);
                    check("hit_rd", rd_o, d_rd);
                    last_rd = rd_o;
                end else begin
                    check("miss_stall", stall_o, (acc_cyc <= d_lat) ? 1 : 0);
                    check("miss_req", mem_req_o, (acc_cyc >= 1) ? 1 : 0);
                    if (acc_cyc >= 1) begin
                        check("mem_we", mem_we_o, d_we);
                        check("mem_addr", mem_addr_o, d_addr);
                        check("mem_be", mem_be_o, d_be);
                        if (d_we) check("mem_wdata", mem_wdata_o, d_wdata);
                        last_be    = mem_be_o;
                        last_wdata = mem_wdata_o;
                    end
                    if (acc_cyc == d_lat + 1 && !d_we) begin
                        check("miss_rd", rd_o, d_rd);
                        last_rd = rd_o;
                    end
                end
            end else if (mon_en) begin
                check("idle_stall", stall_o, 0);
                check("idle_req", mem_req_o, 0);
            end
        end
    end

    task automatic access(input bit re, input bit we, input bit bop, input bit [31:0] addr,
                          input bit [31:0] wd, input int lat, input int flush_at);
        bit [31:0]      w;
        bit             hit;
        bit [31:0]      v;
        bit [31:0]      victims[$];
        int             total;
        w       = {addr[31:2], 2'b00};
        hit     = cached.exists(w);
        d_we    = we;
        d_fast  = !we && hit;
        d_lat   = lat;
        d_addr  = w;
        d_be    = bop ? (4'b0001 << addr[1:0]) : 4'hF;
        d_wdata = bop ? {4{wd[7:0]}} : wd;
        d_rd    = pick(hit ? cached[w] : mem_read(w), addr[1:0], bop);
        resp_lat  = lat;
        re_i      = re;
        we_i      = we;
        byte_op_i = bop;
        addr_i    = addr;
        wd_i      = wd;
        total     = d_fast ? 1 : lat + 2;
        d_active  = 1;
        for (int c = 0; c < total; c++) begin
            acc_cyc = c;
            flush_i = (c == flush_at);
            @(posedge clk);
            #1;
        end
        re_i = 0; we_i = 0; flush_i = 0; d_active = 0;
        if (we) begin
            if (hit) begin
                v = cached[w];
                if (bop) v[8*addr[1:0] +: 8] = wd[7:0];
                else v = wd;
                cached[w] = v;
            end
        end else if (!hit) begin
            foreach (cached[k]) if (line_of(k) == line_of(w)) victims.push_back(k);
            foreach (victims[i]) cached.delete(victims[i]);
            cached[w] = mem_read(w);
        end
        if (flush_at >= 0) cached.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_i = 0; re_i = 0; we_i = 0; byte_op_i = 0; flush_i = 0;
        addr_i = 0; wd_i = 0;
        mem_arr[32'h40]  = 32'hDEAD_BEEF;
        mem_arr[32'h80]  = 32'hCAFE_F00D;
        mem_arr[32'h104] = 32'h0BAD_F00D;
        idle(3);
        check("rst_stall", stall_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_be", mem_be_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        rst_n_i = 1;
        mon_en  = 1;
        idle(2);

        access(1, 0, 0, 32'h40, 0, 3, -1);
        check("cold_stall_cycles", last_stalls, 4);
        check("cold_rd", last_rd, 32'hDEAD_BEEF);
        access(1, 0, 0, 32'h40, 0, 3, -1);
        check("reread_req", last_req_seen, 0);
        check("reread_rd", last_rd, 32'hDEAD_BEEF);
        access(1, 0, 1, 32'h43, 0, 3, -1);
        check("byte_load", last_rd, 32'h0000_00DE);
        access(0, 1, 1, 32'h41, 32'h0000_00A5, 2, -1);
        check("bstore_be", last_be, 4'b0010);
        check("bstore_wdata", last_wdata, 32'hA5A5_A5A5);
        idle(1);
        access(1, 0, 0, 32'h40, 0, 2, -1);
        check("after_bstore_rd", last_rd, 32'hDEAD_A5EF);
        check("after_bstore_stall", last_stalls, 0);

        access(0, 1, 0, 32'h400, 32'h1234_5678, 1, -1);
        access(1, 0, 0, 32'h400, 0, 1, -1);
        check("no_alloc_miss", last_req_seen, 1);
        check("no_alloc_rd", last_rd, 32'h1234_5678);

        access(1, 0, 0, 32'h40, 0, 2, -1);
        check("refill_rd", last_rd, 32'hDEAD_A5EF);
        access(1, 0, 0, 32'h80, 0, 2, -1);
        check("conflict_fill_rd", last_rd, 32'hCAFE_F00D);
        access(1, 0, 0, 32'h40, 0, 1, -1);
        check("conflict_miss", last_req_seen, 1);

        access(1, 0, 0, 32'h104, 0, 0, -1);
        check("lat0_stall_cycles", last_stalls, 1);
        access(1, 0, 1, 32'h106, 0, 0, -1);
        check("byte_lane2", last_rd, 32'h0000_00AD);

        flush_i = 1;
        idle(1);
        flush_i = 0;
        cached.delete();
        access(1, 0, 0, 32'h104, 0, 1, -1);
        check("flush_miss", last_req_seen, 1);

        access(1, 0, 0, 32'h80, 0, 2, 1);
        access(1, 0, 0, 32'h80, 0, 1, -1);
        check("deferred_flush_miss", last_req_seen, 1);

        access(1, 1, 0, 32'h80, 32'h1111_2222, 1, -1);
        access(1, 0, 0, 32'h80, 0, 1, -1);
        check("re_we_store_hit_rd", last_rd, 32'h1111_2222);
        check("re_we_store_no_req", last_req_seen, 0);

        // Reset in the middle of a read miss, then a stray ack.
        mon_en = 0;
        manual_ack = 1;
        mem_ack_i = 0;
        re_i = 1; addr_i = 32'h200; byte_op_i = 0;
        idle(2);
        check("pre_rst_req", mem_req_o, 1);
        check("pre_rst_stall", stall_o, 1);
        rst_n_i = 0;
        re_i = 0;
        idle(1);
        check("midrst_req", mem_req_o, 0);
        check("midrst_stall", stall_o, 0);
        check("midrst_be", mem_be_o, 0);
        check("midrst_addr", mem_addr_o, 0);
        check("midrst_we", mem_we_o, 0);
        rst_n_i = 1;
        cached.delete();
        mem_ack_i = 1;
        mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        check("late_ack_stall", stall_o, 0);
        @(posedge clk);
        #1;
        mem_ack_i = 0;
        check("late_ack_req", mem_req_o, 0);
        manual_ack = 0;
        mon_en = 1;
        idle(2);
        access(1, 0, 0, 32'h200, 0, 1, -1);
        check("post_rst_miss", last_req_seen, 1);
        check("post_rst_rd", last_rd, 32'h5A5A_0200);
        access(1, 0, 0, 32'h80, 0, 1, -1);
        check("post_rst_line_miss", last_req_seen, 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
